// File: rtl/sdram_access_arbiter.sv
// Post-init SDRAM scheduler: two single-word requesters plus periodic auto-refresh.
// Optional build macro SDRAM_ARB_FIXED_PRIO_EN: port 0 always wins, no round-robin pointer.
module sdram_access_arbiter #(
    parameter int unsigned T_RCD        = 2,
    parameter int unsigned T_RP         = 2,
    parameter int unsigned T_WR         = 2,
    parameter int unsigned T_RC         = 7,
    parameter int unsigned CL           = 2,
    parameter int unsigned REF_INTERVAL = 390
) (
    input  logic        iclk,
    input  logic        ireset,
    input  logic        iinit_done,
    input  logic        ireq0,
    input  logic        ireq1,
    input  logic        iwe0,
    input  logic        iwe1,
    input  logic [24:0] iaddr0,
    input  logic [24:0] iaddr1,
    input  logic [15:0] iwdata0,
    input  logic [15:0] iwdata1,
    output logic        ogrant0,
    output logic        ogrant1,
    output logic [15:0] ordata,
    output logic        ordata_valid0,
    output logic        ordata_valid1,
    output logic [3:0]  ocmd,
    output logic [12:0] oaddr,
    output logic [1:0]  oba,
    output logic [1:0]  odqm,
    output logic [15:0] odq_out,
    output logic        odq_oe,
    input  logic [15:0] idq_in,
    output logic        orefresh_miss
);

    localparam int unsigned WAIT_W = 8;
    localparam int unsigned REF_W  = $clog2(REF_INTERVAL) + 1;

    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE  = 4'b0011;
    localparam logic [3:0] CMD_READ    = 4'b0101;
    localparam logic [3:0] CMD_WRITE   = 4'b0100;
    localparam logic [3:0] CMD_REFRESH = 4'b0001;

    typedef enum logic [2:0] {
        WAIT_INIT, IDLE, REFRESH, REF_WAIT, ACTIVATE, RCD_WAIT, RW, ACCESS_WAIT
    } state_t;

    state_t              state, state_n;
    logic [WAIT_W-1:0]   wcnt, wcnt_n;
    logic [REF_W-1:0]    ref_cnt;
    logic                ref_pend, ref_clr;
    logic [24:0]         lat_addr, lat_addr_n;
    logic [15:0]         lat_data, lat_data_n;
    logic                lat_we, lat_we_n;
    logic                lat_port, lat_port_n;
    logic [CL:0]         rd_pipe;
    logic                win;
    logic [3:0]          cmd_n;
    logic [12:0]         addr_n;
    logic [1:0]          ba_n, dqm_n;
    logic [15:0]         dq_out_n;
    logic                dq_oe_n, grant0_n, grant1_n;

    // Arbitration between the two requesters
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        win = !ireq0;
    end
`else
    logic rr, rr_n;
    always_comb begin
        win = (ireq0 && ireq1) ? rr : ireq1;
    end
`endif

    // Next-state and next-output logic
    always_comb begin
        state_n    = state;
        wcnt_n     = wcnt;
        cmd_n      = CMD_NOP;
        addr_n     = 13'd0;
        ba_n       = 2'd0;
        dqm_n      = 2'b11;
        dq_out_n   = 16'd0;
        dq_oe_n    = 1'b0;
        grant0_n   = 1'b0;
        grant1_n   = 1'b0;
        ref_clr    = 1'b0;
        lat_addr_n = lat_addr;
        lat_data_n = lat_data;
        lat_we_n   = lat_we;
        lat_port_n = lat_port;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
        rr_n       = rr;
`endif
        case (state)
            WAIT_INIT: if (iinit_done) state_n = IDLE;
            IDLE: begin
                if (ref_pend) begin
                    state_n = REFRESH;
                    cmd_n   = CMD_REFRESH;
                    ref_clr = 1'b1;
                end else if (ireq0 || ireq1) begin
                    state_n    = ACTIVATE;
                    cmd_n      = CMD_ACTIVE;
                    lat_port_n = win;
                    lat_addr_n = win ? iaddr1 : iaddr0;
                    lat_data_n = win ? iwdata1 : iwdata0;
                    lat_we_n   = win ? iwe1 : iwe0;
                    ba_n       = lat_addr_n[24:23];
                    addr_n     = lat_addr_n[22:10];
                    grant0_n   = !win;
                    grant1_n   = win;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
                    rr_n       = !win;
`endif
                end
            end
            REFRESH: begin
                state_n = REF_WAIT;
                wcnt_n  = WAIT_W'(T_RC - 2);
            end
            ACTIVATE: begin
                if (T_RCD > 1) begin
                    state_n = RCD_WAIT;
                    wcnt_n  = WAIT_W'(T_RCD - 2);
                end else begin
                    state_n = RW;
                end
            end
            RW: begin
                state_n = ACCESS_WAIT;
                wcnt_n  = lat_we ? WAIT_W'(T_WR + T_RP - 1) : WAIT_W'(CL + 8 + T_RP - 1);
            end
            REF_WAIT, RCD_WAIT, ACCESS_WAIT: begin
                if (wcnt == '0) state_n = (state == RCD_WAIT) ? RW : IDLE;
                else            wcnt_n  = wcnt - 1'b1;
            end
            default: state_n = WAIT_INIT;
        endcase

        // Column command with auto-precharge (A10 set)
        if (state_n == RW) begin
            cmd_n  = lat_we ? CMD_WRITE : CMD_READ;
            ba_n   = lat_addr[24:23];
            addr_n = {2'b00, 1'b1, lat_addr[9:0]};
            dqm_n  = 2'b00;
            if (lat_we) begin
                dq_oe_n  = 1'b1;
                dq_out_n = lat_data;
            end
        end
        // Keep byte masks open from READ through the capture cycle
        if ((state == RW && !lat_we) || (rd_pipe[CL-1:0] != '0)) dqm_n = 2'b00;
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state         <= WAIT_INIT;
            wcnt          <= '0;
            ref_cnt       <= '0;
            ref_pend      <= 1'b0;
            lat_addr      <= '0;
            lat_data      <= '0;
            lat_we        <= 1'b0;
            lat_port      <= 1'b0;
            rd_pipe       <= '0;
            ocmd          <= CMD_NOP;
            oaddr         <= '0;
            oba           <= '0;
            odqm          <= 2'b11;
            odq_out       <= '0;
            odq_oe        <= 1'b0;
            ogrant0       <= 1'b0;
            ogrant1       <= 1'b0;
            ordata        <= '0;
            ordata_valid0 <= 1'b0;
            ordata_valid1 <= 1'b0;
            orefresh_miss <= 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            rr            <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            wcnt     <= wcnt_n;
            lat_addr <= lat_addr_n;
            lat_data <= lat_data_n;
            lat_we   <= lat_we_n;
            lat_port <= lat_port_n;
            ocmd     <= cmd_n;
            oaddr    <= addr_n;
            oba      <= ba_n;
            odqm     <= dqm_n;
            odq_out  <= dq_out_n;
            odq_oe   <= dq_oe_n;
            ogrant0  <= grant0_n;
            ogrant1  <= grant1_n;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
            rr       <= rr_n;
`endif
            // Only the first burst word is captured
            rd_pipe       <= {rd_pipe[CL-1:0], (state == RW) && !lat_we};
            ordata_valid0 <= rd_pipe[CL] && !lat_port;
            ordata_valid1 <= rd_pipe[CL] && lat_port;
            if (rd_pipe[CL]) ordata <= idq_in;

            if (state != WAIT_INIT) begin
                if (ref_cnt == REF_W'(REF_INTERVAL - 1)) begin
                    ref_cnt  <= '0;
                    ref_pend <= 1'b1;
                    if (ref_pend && !ref_clr) orefresh_miss <= 1'b1;
                end else begin
                    ref_cnt <= ref_cnt + 1'b1;
                    if (ref_clr) ref_pend <= 1'b0;
                end
            end
        end
    end

endmodule
